// File: rtl/shift_addsub_pipe.sv
// Two-stage pipeline: arithmetic/logical right shift of Y, then add/subtract with X and saturate.
// Define SHIFT_ADDSUB_ROUND_EN to round the shifted operand instead of truncating it.
module shift_addsub_pipe #(
  parameter int DSIZE  = 16,
  parameter int SW     = 5,
  parameter int SIGNED = 0
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DSIZE-1:0] X,
  input  logic [DSIZE-1:0] Y,
  input  logic [SW-1:0]    shift,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] Z,
  output logic             sat
);
  // Two guard bits: one for the rounding carry on Ys, one for the add/sub carry.
  localparam int EW = DSIZE + 2;

  logic             s1_valid;
  logic [DSIZE-1:0] s1_x;
  logic [1:0]       s1_op;
  logic [EW-1:0]    s1_ys;
  logic             s1_adv, s2_adv;
  logic [EW-1:0]    y_ext, y_shr, ys, x_ext, res;
  logic             rnd;
  logic [DSIZE-1:0] z_next;
  logic             sat_next;

  // out_valid doubles as the S2 occupancy flag.
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    if (SIGNED != 0) begin
      y_ext = {{2{Y[DSIZE-1]}}, Y};
      y_shr = $signed(y_ext) >>> shift;
    end else begin
      y_ext = {2'b00, Y};
      y_shr = y_ext >> shift;
    end
    rnd = 1'b0;
`ifdef SHIFT_ADDSUB_ROUND_EN
    for (int i = 0; i < DSIZE; i++)
      if (32'(shift) == i + 1) rnd = Y[i];
`endif
    ys = y_shr + EW'(rnd);
  end

  always_comb begin
    if (SIGNED != 0) x_ext = {{2{s1_x[DSIZE-1]}}, s1_x};
    else             x_ext = {2'b00, s1_x};
    case (s1_op)
      2'b01:   res = x_ext - s1_ys;
      2'b10:   res = x_ext + s1_ys;
      2'b11:   res = s1_ys - x_ext;
      default: res = x_ext;
    endcase
    z_next   = res[DSIZE-1:0];
    sat_next = 1'b0;
    if (SIGNED != 0) begin
      if (res[EW-1] && !(&res[EW-2:DSIZE-1])) begin
        z_next   = {1'b1, {(DSIZE-1){1'b0}}};
        sat_next = 1'b1;
      end else if (!res[EW-1] && (|res[EW-2:DSIZE-1])) begin
        z_next   = {1'b0, {(DSIZE-1){1'b1}}};
        sat_next = 1'b1;
      end
    end else begin
      if (res[EW-1]) begin
        z_next   = '0;
        sat_next = 1'b1;
      end else if (|res[EW-2:DSIZE]) begin
        z_next   = '1;
        sat_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_x      <= '0;
      s1_op     <= '0;
      s1_ys     <= '0;
      out_valid <= 1'b0;
      Z         <= '0;
      sat       <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_x  <= X;
          s1_op <= op;
          s1_ys <= ys;
        end
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          Z   <= z_next;
          sat <= sat_next;
        end
      end
    end
  end
endmodule

// File: tb/tb_shift_addsub_pipe.sv
// Bench for shift_addsub_pipe: unsigned and signed instances share stimulus and are checked
// each cycle against an arithmetic reference model plus hand-computed directed cases.
module tb_shift_addsub_pipe;
  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] x = '0, y = '0;
  logic [4:0]  shift = '0;
  logic [1:0]  op = '0;

  logic        in_ready_u, out_valid_u, sat_u;
  logic        in_ready_s, out_valid_s, sat_s;
  logic [15:0] z_u, z_s;

  always #5 clock = ~clock;

  shift_addsub_pipe #(.DSIZE(16), .SW(5), .SIGNED(0)) dut_u (
    .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
    .X(x), .Y(y), .shift(shift), .op(op),
    .out_valid(out_valid_u), .out_ready(out_ready), .Z(z_u), .sat(sat_u));

  shift_addsub_pipe #(.DSIZE(16), .SW(5), .SIGNED(1)) dut_s (
    .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .X(x), .Y(y), .shift(shift), .op(op),
    .out_valid(out_valid_s), .out_ready(out_ready), .Z(z_s), .sat(sat_s));

  typedef struct {
    longint      acc_edge;
    logic [15:0] zu;
    logic        su;
    logic [15:0] zs;
    logic        ss;
  } ent_t;

  ent_t   q[$];
  longint edge_cnt = 0;
  int     n_checks = 0;
  int     n_fail = 0;

  logic        smp_ov_u, smp_ov_s, smp_ir_u, smp_sat_u, smp_sat_s;
  logic [15:0] smp_z_u, smp_z_s;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: integer arithmetic on the operand values, then clamp to the output range.
  function automatic void ref_calc(input logic [15:0] xi, input logic [15:0] yi, input int sh,
                                   input logic [1:0] o, input bit sgn,
                                   output logic [15:0] z, output logic s);
    longint xv, yv, ys, r, lo, hi;
    if (sgn) begin
      xv = longint'($signed(xi));
      yv = longint'($signed(yi));
      lo = -32768;
      hi = 32767;
    end else begin
      xv = longint'(xi);
      yv = longint'(yi);
      lo = 0;
      hi = 65535;
    end
    ys = yv >>> sh;
`ifdef SHIFT_ADDSUB_ROUND_EN
    if (sh >= 1 && sh <= 16) ys = ys + ((longint'(yi) >> (sh - 1)) & 1);
`endif
    case (o)
      2'b01:   r = xv - ys;
      2'b10:   r = xv + ys;
      2'b11:   r = ys - xv;
      default: r = xv;
    endcase
    s = 1'b0;
    if (r < lo) begin
      r = lo;
      s = 1'b1;
    end else if (r > hi) begin
      r = hi;
      s = 1'b1;
    end
    z = r[15:0];
  endfunction

  // One clock of stimulus; outputs compared against the model queue before the edge.
  task automatic cycle(input bit iv, input bit orr, input logic [15:0] xi, input logic [15:0] yi,
                       input logic [4:0] sh, input logic [1:0] o, output bit acc, output bit pop);
    bit          exp_ir, exp_ov;
    ent_t        e;
    logic [15:0] tz;
    logic        ts;
    @(negedge clock);
    in_valid = iv; out_ready = orr; x = xi; y = yi; shift = sh; op = o;
    #1;
    smp_ov_u = out_valid_u; smp_ov_s = out_valid_s; smp_ir_u = in_ready_u;
    smp_z_u = z_u; smp_z_s = z_s; smp_sat_u = sat_u; smp_sat_s = sat_s;
    exp_ir = (q.size() < 2) || orr;
    exp_ov = (q.size() > 0) && (edge_cnt >= q[0].acc_edge + 1);
    chk("in_ready_u", in_ready_u, exp_ir);
    chk("in_ready_s", in_ready_s, exp_ir);
    chk("out_valid_u", out_valid_u, exp_ov);
    chk("out_valid_s", out_valid_s, exp_ov);
    if (exp_ov) begin
      chk("z_u", z_u, q[0].zu);
      chk("sat_u", sat_u, q[0].su);
      chk("z_s", z_s, q[0].zs);
      chk("sat_s", sat_s, q[0].ss);
    end
    acc = iv && exp_ir;
    pop = exp_ov && orr;
    if (acc) begin
      ref_calc(xi, yi, int'(sh), o, 1'b0, tz, ts);
      e.zu = tz; e.su = ts;
      ref_calc(xi, yi, int'(sh), o, 1'b1, tz, ts);
      e.zs = tz; e.ss = ts;
      e.acc_edge = edge_cnt + 1;
    end
    @(posedge clock);
    edge_cnt++;
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(e);
  endtask

  task automatic dir(input string name, input bit sgn, input logic [15:0] xi, input logic [15:0] yi,
                     input logic [4:0] sh, input logic [1:0] o,
                     input logic [15:0] ez, input logic es);
    logic [15:0] mz;
    logic        ms;
    bit          acc, pop;
    ref_calc(xi, yi, int'(sh), o, sgn, mz, ms);
    chk({name, "_model_z"}, mz, ez);
    chk({name, "_model_sat"}, ms, es);
    cycle(1'b1, 1'b1, xi, yi, sh, o, acc, pop);
    chk({name, "_in_ready"}, smp_ir_u, 1'b1);
    cycle(1'b0, 1'b1, '0, '0, '0, '0, acc, pop);
    chk({name, "_lat1_ov"}, sgn ? smp_ov_s : smp_ov_u, 1'b0);
    cycle(1'b0, 1'b1, '0, '0, '0, '0, acc, pop);
    chk({name, "_lat2_ov"}, sgn ? smp_ov_s : smp_ov_u, 1'b1);
    chk({name, "_z"}, sgn ? smp_z_s : smp_z_u, ez);
    chk({name, "_sat"}, sgn ? smp_sat_s : smp_sat_u, es);
  endtask

  initial begin
    logic [15:0] sx[3];
    logic [15:0] sy[3];
    int          idx, outs;
    bit          acc, pop;

    repeat (3) @(negedge clock);
    chk("reset_out_valid", out_valid_u, 1'b0);
    chk("reset_in_ready", in_ready_u, 1'b1);
    chk("reset_z", z_u, 16'h0000);
    chk("reset_sat_s", sat_s, 1'b0);
    rst_n = 1'b1;

    dir("sub_basic", 1'b0, 16'h0100, 16'h0400, 5'd4, 2'b01, 16'h00C0, 1'b0);
    dir("sub_underflow", 1'b0, 16'h0010, 16'h0400, 5'd2, 2'b01, 16'h0000, 1'b1);
    dir("add_overflow", 1'b0, 16'hFFF0, 16'h0100, 5'd0, 2'b10, 16'hFFFF, 1'b1);
    dir("s_add_overflow", 1'b1, 16'h7FF0, 16'h0200, 5'd1, 2'b10, 16'h7FFF, 1'b1);
    dir("s_big_shift", 1'b1, 16'h0000, 16'h8000, 5'd20, 2'b01, 16'h0001, 1'b0);
    dir("s_pass", 1'b1, 16'h8000, 16'h1234, 5'd3, 2'b00, 16'h8000, 1'b0);
    dir("rev_sub", 1'b0, 16'h0005, 16'h0010, 5'd0, 2'b11, 16'h000B, 1'b0);
`ifdef SHIFT_ADDSUB_ROUND_EN
    dir("round_bit0", 1'b0, 16'h0000, 16'h0003, 5'd1, 2'b10, 16'h0002, 1'b0);
    dir("round_full", 1'b0, 16'h0000, 16'h8000, 5'd16, 2'b10, 16'h0001, 1'b0);
`else
    dir("round_bit0", 1'b0, 16'h0000, 16'h0003, 5'd1, 2'b10, 16'h0001, 1'b0);
    dir("round_full", 1'b0, 16'h0000, 16'h8000, 5'd16, 2'b10, 16'h0000, 1'b0);
`endif

    // Backpressure: 5 stalled cycles with 3 items offered, then drain.
    sx[0] = 16'h1000; sx[1] = 16'h2000; sx[2] = 16'h3000;
    sy[0] = 16'h0100; sy[1] = 16'h0200; sy[2] = 16'h0300;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      cycle(idx < 3, 1'b0, sx[idx < 3 ? idx : 2], sy[idx < 3 ? idx : 2], 5'd4, 2'b10, acc, pop);
      if (acc) idx++;
    end
    chk("stall_accepted", 64'(idx), 64'd2);
    chk("stall_in_ready", smp_ir_u, 1'b0);
    chk("stall_z_held", smp_z_u, 16'h1010);
    outs = 0;
    for (int c = 0; c < 12 && outs < 3; c++) begin
      cycle(idx < 3, 1'b1, sx[idx < 3 ? idx : 2], sy[idx < 3 ? idx : 2], 5'd4, 2'b10, acc, pop);
      if (acc) idx++;
      if (pop) outs++;
    end
    chk("stall_drain_count", 64'(outs), 64'd3);

    // Reset with both stages full.
    cycle(1'b1, 1'b0, 16'h0AAA, 16'h0055, 5'd1, 2'b10, acc, pop);
    cycle(1'b1, 1'b0, 16'h0BBB, 16'h0066, 5'd2, 2'b01, acc, pop);
    @(negedge clock);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ov_u", out_valid_u, 1'b0);
    chk("rst_mid_ov_s", out_valid_s, 1'b0);
    chk("rst_mid_z", z_u, 16'h0000);
    chk("rst_mid_sat", sat_u, 1'b0);
    chk("rst_mid_in_ready", in_ready_u, 1'b1);
    q.delete();
    repeat (2) @(negedge clock);
    chk("rst_hold_in_ready", in_ready_s, 1'b1);
    rst_n = 1'b1;
    cycle(1'b0, 1'b1, '0, '0, '0, '0, acc, pop);
    dir("post_reset", 1'b0, 16'h0100, 16'h0400, 5'd4, 2'b01, 16'h00C0, 1'b0);

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
            5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), acc, pop);
    end
    for (int c = 0; c < 6; c++) cycle(1'b0, 1'b1, '0, '0, '0, '0, acc, pop);
    chk("final_empty", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
